// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial add/subtract engine: one full_adder cell is time-shared across
// WIDTH clock cycles, LSB first, with valid/ready handshakes on both sides.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for a request, in_ready high
//  RUN   | one result bit per clock through the shared full adder
//  DONE  | result presented on out_*, held until out_ready

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    // Single-bit sum and carry
    always_comb begin
        o_s    = i_a ^ i_b ^ i_cin;
        o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
    end
endmodule

module bit_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic             w_accept;

    // The only adder in the design; subtraction arrives as A + ~B + 1
    full_adder u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = in_valid && (r_state == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: begin
                w_next   = S_IDLE;
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Operand shifting, carry chain, and result capture on the final bit.
    // The carry register during the last bit is the carry into the MSB,
    // so overflow is formed directly from it and the MSB carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= in_acc ? r_acc : in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= {w_s, r_res[WIDTH-1:1]};
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_acc  <= {w_s, r_res[WIDTH-1:1]};
                r_cout <= w_cout;
                r_ovf  <= r_carry ^ w_cout;
            end
        end
    end

    // The accumulator doubles as the presented result
    assign out_sum  = r_acc;
    assign out_cout = r_cout;
    assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed and random bench for bit_serial_add_ctrl (WIDTH=8 and WIDTH=2 builds)
module tb_bit_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0, in_sub = 1'b0, in_acc = 1'b0, out_ready = 1'b0;
    logic [7:0] in_a = '0, in_b = '0;
    logic       in_ready, out_valid, out_cout, out_ovf, busy;
    logic [7:0] out_sum;

    logic       v2 = 1'b0, sub2 = 1'b0, acc2 = 1'b0, ordy2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       rdy2, ov2, cout2, ovf2, busy2;
    logic [1:0] sum2;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] ref_acc8 = 0;
    logic [31:0] ref_acc2 = 0;

    always #5 clk = ~clk;

    bit_serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_acc(in_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
    );

    bit_serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .in_a(a2), .in_b(b2), .in_sub(sub2), .in_acc(acc2),
        .out_valid(ov2), .out_ready(ordy2), .out_sum(sum2),
        .out_cout(cout2), .out_ovf(ovf2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: modulo 2^w add/sub, carry from the wide sum,
    // overflow from operand and result signs
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, output logic [31:0] s, output logic c,
                         output logic o);
        longint mask, bb, full;
        logic sa, sb, ss;
        mask = (longint'(1) << w) - 1;
        bb   = sub ? (((~longint'(b)) & mask) + 1) : (longint'(b) & mask);
        full = (longint'(a) & mask) + bb;
        s    = 32'(full & mask);
        c    = full[w];
        sa   = a[w-1];
        sb   = b[w-1];
        ss   = s[w-1];
        o    = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                           input logic acc, input int hold);
        int guard;
        int lat;
        logic [31:0] es;
        logic ec, eo;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check("ready_wait8", {31'd0, in_ready}, 32'd1);
        model(8, acc ? ref_acc8 : {24'd0, a}, {24'd0, b}, sub, es, ec, eo);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_acc = acc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom);
        in_sub = 1'($urandom); in_acc = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("latency8", lat, 8);
        check("sum8", {24'd0, out_sum}, es);
        check("cout8", {31'd0, out_cout}, {31'd0, ec});
        check("ovf8", {31'd0, out_ovf}, {31'd0, eo});
        check("busy_done8", {30'd0, busy, in_ready}, 32'h2);
        ref_acc8 = es;
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            in_a = 8'($urandom);
            @(posedge clk); #1;
            check("hold_sum8", {24'd0, out_sum}, es);
            check("hold_flags8", {28'd0, out_valid, busy, in_ready, out_cout ^ out_ovf},
                  {28'd0, 1'b1, 1'b1, 1'b0, ec ^ eo});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff8", {29'd0, out_valid, busy, in_ready}, 32'h1);
    endtask

    task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic sub,
                           input logic acc);
        int lat;
        logic [31:0] es;
        logic ec, eo;
        check("ready2", {31'd0, rdy2}, 32'd1);
        model(2, acc ? ref_acc2 : {30'd0, a}, {30'd0, b}, sub, es, ec, eo);
        v2 = 1'b1; a2 = a; b2 = b; sub2 = sub; acc2 = acc;
        @(posedge clk); #1;
        v2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
        lat = 0;
        while (!ov2 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("latency2", lat, 2);
        check("sum2", {30'd0, sum2}, es);
        check("cout2", {31'd0, cout2}, {31'd0, ec});
        check("ovf2", {31'd0, ovf2}, {31'd0, eo});
        ref_acc2 = es;
        ordy2 = 1'b1;
        @(posedge clk); #1;
        ordy2 = 1'b0;
        check("handoff2", {30'd0, ov2, busy2}, 32'd0);
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_flags", {27'd0, in_ready, out_valid, busy, out_cout, out_ovf}, 32'h10);
        check("rst_sum", {24'd0, out_sum}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases
        run_op8(8'h35, 8'h4A, 1'b0, 1'b0, 0);
        check("dir_7f", {24'd0, out_sum}, 32'h7F);
        run_op8(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        check("dir_80", {22'd0, out_sum, out_cout, out_ovf}, {22'd0, 8'h80, 2'b01});
        run_op8(8'hFF, 8'h80, 1'b0, 1'b1, 0);
        check("dir_acc", {22'd0, out_sum, out_cout, out_ovf}, {22'd0, 8'h00, 2'b11});
        run_op8(8'h10, 8'h20, 1'b1, 1'b0, 0);
        check("dir_sub1", {22'd0, out_sum, out_cout, out_ovf}, {22'd0, 8'hF0, 2'b00});
        run_op8(8'h80, 8'h01, 1'b1, 1'b0, 5);
        check("dir_sub2", {22'd0, out_sum, out_cout, out_ovf}, {22'd0, 8'h7F, 2'b11});

        // Immediate re-accept right after handoff
        run_op8(8'h01, 8'h02, 1'b0, 1'b0, 0);

        // Reset during RUN at bit 3
        in_valid = 1'b1; in_a = 8'h55; in_b = 8'h33; in_sub = 1'b0; in_acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst", {29'd0, out_valid, busy, in_ready}, 32'h1);
        check("mid_rst_sum", {24'd0, out_sum}, 32'd0);
        ref_acc8 = 0;
        ref_acc2 = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op8(8'hFF, 8'h05, 1'b0, 1'b1, 0);
        check("acc_cleared", {24'd0, out_sum}, 32'h05);

        // Random operations with random backpressure
        for (int k = 0; k < 24; k++)
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)));

        // WIDTH=2 build
        run_op2(2'h3, 2'h1, 1'b0, 1'b0);
        check("w2_dir", {29'd0, sum2, cout2}, {29'd0, 2'h0, 1'b1});
        for (int k = 0; k < 10; k++)
            run_op2(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bit_serial_add_ctrl.md
Name: bit_serial_add_ctrl

Overview:
- Sequencer that time-shares one full_adder cell to perform WIDTH-bit add/subtract, one bit per clock, LSB first.
- Holds operand shift registers, a carry flop, a bit counter and a result accumulator; valid/ready on both sides.
- Area-minimal add/accumulate engine for NPU partial-sum reduction.
- Instantiates exactly one full_adder; no other adder logic permitted.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  controller can accept a request
- in_a  input  WIDTH  operand A (ignored when in_acc=1)
- in_b  input  WIDTH  operand B
- in_sub  input  1  1: A - B; 0: A + B
- in_acc  input  1  1: use accumulator as A
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  final carry out (sub: 1 = no borrow)
- out_ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync-free release): state=IDLE; in_ready=1; out_valid=0; out_sum=0; out_cout=0; out_ovf=0; busy=0; accumulator=0; carry=0; counter=0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge T: latch A (accumulator if in_acc, else in_a); latch B (~in_b if in_sub, else in_b); carry <= in_sub; counter <= 0; go to RUN.
- RUN: in_ready=0. Each cycle feeds A[0], B[0], carry into full_adder; s shifts into result MSB, A/B shift right, carry <= cout, counter++. At counter=WIDTH-1, capture carry-into-MSB (adder cin) for overflow, then go to DONE.
- Latency: out_valid rises exactly WIDTH clocks after the accepting edge T (first cycle of DONE = T+WIDTH+1).
- DONE: out_valid=1; out_sum/out_cout/out_ovf/accumulator updated on entry. out_ovf = cin_msb XOR cout_msb. Outputs held stable while out_ready=0. On out_ready, go to IDLE; out_valid drops next cycle.
- Throughput: no overlap; in_ready is low in RUN and DONE, so next accept is at the earliest one cycle after result handoff. Max one op per WIDTH+2 cycles.
- in_valid while not ready: ignored; inputs not sampled. Input fields only sampled at the accept edge; later changes have no effect.
- Accumulator holds the last completed out_sum. It updates on DONE entry, not on handoff. Only reset clears it.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Reset mid-RUN or mid-DONE: operation aborted, all state as at reset, no result emitted.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, accept in_a=0x35, in_b=0x4A, add -> out_valid exactly 8 clocks after accept edge; out_sum=0x7F, cout=0, ovf=0.
- in_a=0x7F, in_b=0x01, add -> out_sum=0x80, cout=0, ovf=1. Then in_acc=1, in_b=0x80, add -> out_sum=0x00, cout=1, ovf=1; in_a value ignored (drive 0xFF).
- in_a=0x10, in_b=0x20, sub -> out_sum=0xF0, cout=0, ovf=0. in_a=0x80, in_b=0x01, sub -> out_sum=0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_sum/cout/ovf stable, in_ready=0, busy=1. Toggling in_valid/in_a during this time changes nothing. Raise out_ready -> IDLE next cycle; new request accepted one cycle after.
- Deassert rst_n during RUN at bit 3 -> immediately out_valid=0, busy=0, in_ready=1. A following in_acc=1 add of in_b=0x05 yields 0x05 (accumulator cleared).
- WIDTH=2 build: in_a=0x3, in_b=0x1, add -> out_sum=0x0, cout=1, ovf=0, latency 2 clocks.
